// File: rtl/rc5_loader_pkg.sv
// rc5_loader_pkg
// Shared constants for the RC5 stream loader: word/key/block widths, group
// sizes and the FSM state encoding (plain localparams so the encoding stays
// visible in legacy tools and waveform viewers).
// No ports. Optional feature macro used by the top: RC5_LOADER_TIMEOUT_EN.
package rc5_loader_pkg;

    localparam int WORD_W    = 32;
    localparam int KEY_WORDS = 4;
    localparam int BLK_WORDS = 2;
    localparam int KEY_W     = WORD_W * KEY_WORDS;  // 128
    localparam int BLK_W     = WORD_W * BLK_WORDS;  // 64

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_COLLECT  = 3'd1;
    localparam state_t ST_ISSUE    = 3'd2;
    localparam state_t ST_WAIT_KEY = 3'd3;
    localparam state_t ST_WAIT_BLK = 3'd4;

    // A block or key is owned by the core from ISSUE until its handshake.
    function automatic logic state_is_busy(input state_t s);
        return (s == ST_ISSUE) || (s == ST_WAIT_KEY) || (s == ST_WAIT_BLK);
    endfunction

endpackage

// File: rtl/rc5_word_packer.sv
// rc5_word_packer
// Shift-in register that assembles 32-bit stream words into a 128-bit value,
// first word in the MSBs. Key groups use all 128 bits; data groups use the
// lower 64 bits (the two most recent words).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         discard the partial group (word index back to 0)
//   shift_en      accept word this cycle
//   is_key        group type: selects 4-word (1) or 2-word (0) group length
//   word          incoming stream word
//   packed_nxt    accumulated words with the current word appended
//   done          shift_en on the word that completes the group
module rc5_word_packer
    import rc5_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              is_key,
    input  logic [WORD_W-1:0] word,
    output logic [KEY_W-1:0]  packed_nxt,
    output logic              done
);

    logic [1:0]              idx_q, idx_d;
    logic [KEY_W-WORD_W-1:0] acc_q, acc_d;
    logic                    last;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        packed_nxt = {acc_q, word};
        last       = is_key ? (idx_q == 2'(KEY_WORDS - 1))
                            : (idx_q == 2'(BLK_WORDS - 1));
        done       = shift_en && last;
        idx_d      = idx_q;
        acc_d      = acc_q;
        if (clear) begin
            idx_d = '0;
        end else if (shift_en) begin
            acc_d = packed_nxt[KEY_W-WORD_W-1:0];
            idx_d = last ? 2'd0 : idx_q + 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            acc_q <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/rc5_stream_loader.sv
// rc5_stream_loader
// Upstream feeder for the RC5 core. Packs a valid/ready 32-bit word stream into
// 128-bit key loads and 64-bit data blocks, and sequences the core's
// key_en/key_ok and din_en/dout_en handshakes with exactly one item in flight.
// Optional feature: define RC5_LOADER_TIMEOUT_EN to abandon a wait after
// WAIT_MAX cycles (sets err, returns to IDLE).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_word/in_valid/in_ready, in_is_key, in_mode   input stream
//   key, key_en, key_ok    key load interface to the core
//   din, din_en, flag      block issue interface to the core
//   core_dout_en           core result valid, completes the block
//   key_loaded, busy, blk_count, err   status
module rc5_stream_loader
    import rc5_loader_pkg::*;
#(
    parameter int WAIT_MAX = 1024,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    input  logic              in_is_key,
    input  logic              in_mode,
    output logic              in_ready,
    output logic [KEY_W-1:0]  key,
    output logic              key_en,
    input  logic              key_ok,
    output logic [BLK_W-1:0]  din,
    output logic              din_en,
    output logic              flag,
    input  logic              core_dout_en,
    output logic              key_loaded,
    output logic              busy,
    output logic [CNT_W-1:0]  blk_count,
    output logic              err
);

    if (WAIT_MAX < 1) begin : g_bad_wait_max
        $error("WAIT_MAX must be at least 1");
    end

    state_t             state_q, state_d;
    logic               grp_key_q, grp_key_d;
    logic               grp_mode_q, grp_mode_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [BLK_W-1:0]   din_q, din_d;
    logic               flag_q, flag_d;
    logic               key_en_q, key_en_d;
    logic               din_en_q, din_en_d;
    logic               in_ready_q, in_ready_d;
    logic               key_loaded_q, key_loaded_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   blk_count_q, blk_count_d;
    logic               err_q, err_d;

    logic               xfer;
    logic               pk_clear, pk_shift, pk_is_key, pk_done;
    logic [KEY_W-1:0]   pk_packed;
    logic               wait_expired;

    assign xfer = in_valid && in_ready_q;

    rc5_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .shift_en   (pk_shift),
        .is_key     (pk_is_key),
        .word       (in_word),
        .packed_nxt (pk_packed),
        .done       (pk_done)
    );

`ifdef RC5_LOADER_TIMEOUT_EN
    localparam int WAIT_CNT_W = $clog2(WAIT_MAX + 1);
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counts cycles spent in the current wait; the WAIT_MAX-th cycle without
    // the handshake expires it.
    always_comb begin
        wait_cnt_d   = '0;
        wait_expired = 1'b0;
        if (state_q == ST_WAIT_KEY || state_q == ST_WAIT_BLK) begin
            wait_cnt_d   = wait_cnt_q + 1'b1;
            wait_expired = (wait_cnt_q == WAIT_CNT_W'(WAIT_MAX - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grp_key_d    = grp_key_q;
        grp_mode_d   = grp_mode_q;
        key_d        = key_q;
        din_d        = din_q;
        flag_d       = flag_q;
        key_loaded_d = key_loaded_q;
        blk_count_d  = blk_count_q;
        err_d        = err_q;
        pk_clear     = 1'b0;
        pk_shift     = 1'b0;
        pk_is_key    = grp_key_q;

        case (state_q)
            ST_IDLE: begin
                // Group length for the first word comes straight from the input.
                pk_is_key = in_is_key;
                if (xfer) begin
                    grp_key_d = in_is_key;
                    if (!in_is_key) grp_mode_d = in_mode;
                    pk_shift  = 1'b1;
                    state_d   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (xfer) begin
                    if (in_is_key != grp_key_q) begin
                        // Mixed group: drop the word and the partial group.
                        err_d    = 1'b1;
                        pk_clear = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        pk_shift = 1'b1;
                        if (pk_done) begin
                            if (grp_key_q) begin
                                key_d   = pk_packed;
                                state_d = ST_ISSUE;
                            end else if (!key_loaded_q) begin
                                // No key in the core yet: discard the block.
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                din_d   = pk_packed[BLK_W-1:0];
                                flag_d  = grp_mode_q;
                                state_d = ST_ISSUE;
                            end
                        end
                    end
                end
            end
            ST_ISSUE: begin
                state_d = grp_key_q ? ST_WAIT_KEY : ST_WAIT_BLK;
            end
            ST_WAIT_KEY: begin
                if (key_ok) begin
                    key_loaded_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_BLK: begin
                if (core_dout_en) begin
                    blk_count_d = blk_count_q + 1'b1;
                    state_d     = ST_IDLE;
                end else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake and status outputs are registered from the next state so
        // they line up with the state they describe.
        key_en_d   = (state_d == ST_ISSUE) &&  grp_key_d;
        din_en_d   = (state_d == ST_ISSUE) && !grp_key_d;
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
        busy_d     = state_is_busy(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grp_key_q    <= 1'b0;
            grp_mode_q   <= 1'b0;
            key_q        <= '0;
            din_q        <= '0;
            flag_q       <= 1'b0;
            key_en_q     <= 1'b0;
            din_en_q     <= 1'b0;
            in_ready_q   <= 1'b0;
            key_loaded_q <= 1'b0;
            busy_q       <= 1'b0;
            blk_count_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grp_key_q    <= grp_key_d;
            grp_mode_q   <= grp_mode_d;
            key_q        <= key_d;
            din_q        <= din_d;
            flag_q       <= flag_d;
            key_en_q     <= key_en_d;
            din_en_q     <= din_en_d;
            in_ready_q   <= in_ready_d;
            key_loaded_q <= key_loaded_d;
            busy_q       <= busy_d;
            blk_count_q  <= blk_count_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign key        = key_q;
    assign key_en     = key_en_q;
    assign din        = din_q;
    assign din_en     = din_en_q;
    assign flag       = flag_q;
    assign key_loaded = key_loaded_q;
    assign busy       = busy_q;
    assign blk_count  = blk_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rc5_stream_loader.sv
// tb_rc5_stream_loader
// Directed bench for rc5_stream_loader: key load, data block, backpressure,
// counter wrap, mixed group, block without key, and (with
// RC5_LOADER_TIMEOUT_EN) wait timeout and reset during a wait.
module tb_rc5_stream_loader;

    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 8;

    localparam logic [127:0] KEY_A = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] KEY_B = 128'h00112233445566778899AABBCCDDEEFF;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       in_word;
    logic              in_valid, in_is_key, in_mode, in_ready;
    logic [127:0]      key;
    logic              key_en, key_ok;
    logic [63:0]       din;
    logic              din_en, flag, core_dout_en;
    logic              key_loaded, busy, err;
    logic [CNT_W-1:0]  blk_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rc5_stream_loader #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_word      (in_word),
        .in_valid     (in_valid),
        .in_is_key    (in_is_key),
        .in_mode      (in_mode),
        .in_ready     (in_ready),
        .key          (key),
        .key_en       (key_en),
        .key_ok       (key_ok),
        .din          (din),
        .din_en       (din_en),
        .flag         (flag),
        .core_dout_en (core_dout_en),
        .key_loaded   (key_loaded),
        .busy         (busy),
        .blk_count    (blk_count),
        .err          (err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until the loader takes it (bounded).
    task automatic send_word(input logic [31:0] w, input logic k, input logic m);
        logic taken;
        taken     = 1'b0;
        in_word   = w;
        in_valid  = 1'b1;
        in_is_key = k;
        in_mode   = m;
        for (int i = 0; i < 20 && !taken; i++) begin
            taken = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("word_accepted", taken, 1'b1);
    endtask

    task automatic send_key(input logic [127:0] k);
        logic [127:0] kv;
        kv = k;
        for (int i = 3; i >= 0; i--) send_word(kv[i*32 +: 32], 1'b1, 1'b0);
    endtask

    task automatic pulse_key_ok();
        key_ok = 1'b1;
        tick();
        key_ok = 1'b0;
    endtask

    task automatic pulse_dout_en();
        core_dout_en = 1'b1;
        tick();
        core_dout_en = 1'b0;
    endtask

    task automatic run_block(input logic [31:0] w0, input logic [31:0] w1);
        send_word(w0, 1'b0, 1'b0);
        send_word(w1, 1'b0, 1'b0);
        tick();
        pulse_dout_en();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_word = '0; in_valid = 1'b0; in_is_key = 1'b0; in_mode = 1'b0;
        key_ok = 1'b0; core_dout_en = 1'b0;
        tick();
        tick();

        // Reset values, held while rst is high.
        check("rst_key", key, '0);
        check("rst_din", din, '0);
        check("rst_strobes", {flag, key_en, din_en, in_ready}, 4'b0000);
        check("rst_status", {key_loaded, busy, err}, 3'b000);
        check("rst_blk_count", blk_count, '0);
        rst = 1'b0;
        tick();
        check("idle_ready", in_ready, 1'b1);

        // Key load: ISSUE is the cycle after the fourth word.
        send_key(KEY_A);
        check("key_value", key, KEY_A);
        check("key_issue", {key_en, busy, in_ready}, 3'b110);
        tick();
        check("key_en_one_cycle", {key_en, busy, in_ready}, 3'b010);
        repeat (4) tick();
        check("key_wait_not_loaded", key_loaded, 1'b0);
        pulse_key_ok();
        check("key_loaded", {key_loaded, in_ready, busy}, 3'b110);

        // Data block with mode=1.
        send_word(32'hDEADBEEF, 1'b0, 1'b1);
        send_word(32'h00C0FFEE, 1'b0, 1'b0);
        check("blk_din", din, 64'hDEADBEEF00C0FFEE);
        check("blk_issue", {flag, din_en, key_en, in_ready, busy}, 5'b11001);

        // Backpressure: in_valid held high through WAIT_BLK.
        in_word = 32'h11111111; in_valid = 1'b1; in_is_key = 1'b0; in_mode = 1'b0;
        tick();
        check("din_en_one_cycle", din_en, 1'b0);
        repeat (3) tick();
        check("bp_not_ready", in_ready, 1'b0);
        check("bp_din_stable", {flag, din}, {1'b1, 64'hDEADBEEF00C0FFEE});
        pulse_dout_en();
        check("blk_count_1", blk_count, 4'd1);
        check("bp_ready_after_done", {in_ready, busy}, 2'b10);
        tick();
        in_valid = 1'b0;
        check("bp_first_word_held_din", din, 64'hDEADBEEF00C0FFEE);
        send_word(32'h22222222, 1'b0, 1'b0);
        check("bp_din", din, 64'h1111111122222222);
        check("bp_flag_din_en", {flag, din_en}, 2'b01);
        tick();
        pulse_dout_en();
        check("blk_count_2", blk_count, 4'd2);

        // Completion handshakes outside their wait state are ignored.
        pulse_dout_en();
        check("stray_dout_en", blk_count, 4'd2);

        // Counter wrap at 2^CNT_W-1 -> 0.
        for (int i = 0; i < 13; i++) run_block(32'h0 + i, 32'hA5A5A5A5);
        check("blk_count_15", blk_count, 4'd15);
        run_block(32'hCAFEF00D, 32'h12345678);
        check("blk_count_wrap", {err, blk_count}, {1'b0, 4'd0});

        // Mixed group: key, key, data -> error, no key_en, key unchanged.
        send_word(32'hA0A0A0A0, 1'b1, 1'b0);
        send_word(32'hA1A1A1A1, 1'b1, 1'b0);
        send_word(32'hB0B0B0B0, 1'b0, 1'b0);
        check("mixed_err", {err, key_en, busy, in_ready}, 4'b1001);
        check("mixed_key_kept", key, KEY_A);
        tick();
        check("mixed_no_key_en", key_en, 1'b0);
        send_key(KEY_B);
        check("reload_key", {key_en, key}, {1'b1, KEY_B});
        tick();
        key_ok = 1'b1;               // level-style key_ok
        tick();
        tick();
        key_ok = 1'b0;
        check("reload_done", {key_loaded, busy, in_ready}, 3'b101);

        // Data group right after reset: discarded, no din_en.
        do_reset();
        check("rst2_clear", {err, key_loaded, busy, in_ready}, 4'b0001);
        check("rst2_key", key, '0);
        pulse_key_ok();
        check("stray_key_ok", key_loaded, 1'b0);
        send_word(32'h13572468, 1'b0, 1'b1);
        send_word(32'h24681357, 1'b0, 1'b1);
        check("nokey_err", {err, din_en, busy, in_ready}, 4'b1001);
        check("nokey_din_blk", {din, blk_count}, {64'h0, 4'd0});
        tick();
        check("nokey_no_din_en", din_en, 1'b0);

`ifdef RC5_LOADER_TIMEOUT_EN
        // WAIT_BLK times out WAIT_MAX cycles after entry.
        do_reset();
        send_key(KEY_A);
        tick();
        pulse_key_ok();
        send_word(32'h55555555, 1'b0, 1'b0);
        send_word(32'h66666666, 1'b0, 1'b0);
        tick();                       // first WAIT_BLK cycle
        repeat (WAIT_MAX - 1) tick();
        check("to_before", {err, busy}, 2'b01);
        tick();
        check("to_expired", {err, busy, in_ready}, 3'b101);
        check("to_blk_count", blk_count, 4'd0);

        // Reset in the middle of WAIT_BLK.
        send_word(32'h77777777, 1'b0, 1'b0);
        send_word(32'h88888888, 1'b0, 1'b0);
        repeat (3) tick();
        check("mid_wait_busy", {busy, err}, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_wait_rst", {busy, err}, 2'b00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
